ama_riscv_fetch_buffer: RTL and testbench

- Small in-order FIFO between the instruction-memory response and the decode stage.
- Decouples fetch from decode stalls.
- The head entry's instruction word feeds decode, and decode in turn drives the immediate generator with inst[31:7] and ig_sel.
- Supports a front-end flush on redirect (branch/jump/trap) that discards every buffered instruction in one cycle.

---
 rtl/ama_riscv_fetch_buffer_pkg.sv | 9 +
 rtl/ama_riscv_fetch_buffer.sv | 47 ++++
 tb/tb_ama_riscv_fetch_buffer.sv | 103 ++++++++++
 3 files changed

// File: rtl/ama_riscv_fetch_buffer_pkg.sv
// ama_riscv_fetch_buffer_pkg: shared types and constants for the fetch buffer
package ama_riscv_fetch_buffer_pkg;
   typedef logic [31:0] arch_width_t;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   typedef struct packed {
      logic [31:0] inst;
      arch_width_t pc;
   } fb_entry_t;
endpackage

// File: rtl/ama_riscv_fetch_buffer.sv
// ama_riscv_fetch_buffer: in-order instruction FIFO between IMEM response and decode
module ama_riscv_fetch_buffer
   import ama_riscv_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  arch_width_t      in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output arch_width_t      out_pc,
   output logic [PTR_W:0]   count
);
   fb_entry_t mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic push, pop;
   assign in_ready = count != (PTR_W+1)'(DEPTH);
   assign out_valid = count != '0;
   assign push = in_valid & in_ready & ~flush;
   assign pop = out_valid & out_ready & ~flush;
   assign out_inst = out_valid ? mem[rd_ptr].inst : INST_NOP;
   assign out_pc = out_valid ? mem[rd_ptr].pc : '0;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
   a_count_max: assert property (@(posedge clk) disable iff (rst) count <= (PTR_W+1)'(DEPTH));
   a_count_ptr: assert property (@(posedge clk) disable iff (rst) count[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr));
   a_stable: assert property (@(posedge clk) disable iff (rst)
      out_valid && !out_ready && !flush |=> $stable(out_inst) && $stable(out_pc));
endmodule

// File: tb/tb_ama_riscv_fetch_buffer.sv
// tb_ama_riscv_fetch_buffer: scoreboard bench for the fetch buffer
module tb_ama_riscv_fetch_buffer;
   import ama_riscv_fetch_buffer_pkg::*;
   logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
   logic [31:0] in_inst = '0;
   arch_width_t in_pc = '0;
   logic in_ready, out_valid;
   logic [31:0] out_inst;
   arch_width_t out_pc;
   logic [2:0] count;
   int vectors = 0, miscompares = 0, m_cnt = 0;
   bit started = 0;
   fb_entry_t q[$];

   ama_riscv_fetch_buffer #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .count(count));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   always @(negedge clk)
      if (started && !rst && out_valid === 1'b1) begin
         if (q.size() == 0) chk("head_unexpected", 32'd1, 32'd0);
         else begin
            chk("head_inst", out_inst, q[0].inst);
            chk("head_pc", out_pc, q[0].pc);
            if (out_ready && !flush) void'(q.pop_front());
         end
      end

   task automatic cyc(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl);
      bit ps, pp;
      rst = r; in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
      @(negedge clk);
      chk("count", 32'(count), 32'(m_cnt));
      chk("in_ready", 32'(in_ready), 32'(m_cnt != 4));
      chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      if (m_cnt == 0) begin
         chk("idle_inst", out_inst, INST_NOP);
         chk("idle_pc", out_pc, 32'h0);
      end
      ps = v && !fl && !r && m_cnt < 4;
      pp = rdy && m_cnt > 0 && !fl && !r;
      @(posedge clk); #1;
      if (r || fl) begin
         q.delete();
         m_cnt = 0;
      end else begin
         if (ps) q.push_back('{inst: inst, pc: pc});
         m_cnt += int'(ps) - int'(pp);
      end
   endtask

   task automatic idle(input logic rdy);
      cyc(0, 0, 32'h0, 32'h0, rdy, 0);
   endtask

   task automatic psh(input logic [31:0] pc, input logic rdy);
      cyc(0, 1, 32'h0010_0093 + pc, pc, rdy, 0);
   endtask

   initial begin
      @(posedge clk); #1;
      started = 1;
      cyc(1, 0, 32'h0, 32'h0, 0, 0);
      idle(0);
      cyc(0, 1, 32'h0050_0093, 32'h100, 0, 0);
      idle(1);
      idle(0);
      for (int i = 0; i < 5; i++) psh(32'(i * 4), 0);
      for (int i = 0; i < 5; i++) idle(1);
      psh(32'h200, 0);
      psh(32'h204, 0);
      for (int i = 0; i < 10; i++) psh(32'h208 + 32'(i * 4), 1);
      idle(1);
      idle(1);
      idle(0);
      for (int i = 0; i < 3; i++) psh(32'h300 + 32'(i * 4), 0);
      cyc(0, 1, 32'h0bad_0093, 32'h3f0, 1, 1);
      idle(0);
      psh(32'h400, 0);
      idle(1);
      idle(0);
      psh(32'h500, 0);
      psh(32'h504, 0);
      cyc(1, 1, 32'h0bad_0113, 32'h508, 0, 0);
      idle(0);
      idle(1);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
